fir_decim_mc: RTL and testbench

FIR_DECIM_MC -- requirements
Module: fir_decim_mc

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fifo.sv | 56 +++++
 rtl/fir_decim_mc.sv | 148 ++++++++++++++
 tb/tb_fir_decim_mc.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the decimating multi-channel FIR: fixed-point scaling,
// power-on coefficient table and core FSM states.
package fir_pkg;

  // Products are scaled down by 2^FRAC_BITS before accumulation.
  localparam int FRAC_BITS = 10;

  // Coefficients loaded on reset; tap i gets entry (i mod COEF_TABLE_LEN).
  localparam int COEF_TABLE_LEN = 32;
  localparam logic signed [31:0] DEFAULT_COEF [COEF_TABLE_LEN] = '{
    32'sd1024,  32'sd2048,  32'sd3072,  32'sd4096,  32'sd5120,  32'sd6144,  32'sd7168,  32'sd8192,
    32'sd9216,  32'sd10240, 32'sd11264, 32'sd12288, 32'sd13312, 32'sd14336, 32'sd15360, 32'sd16384,
    32'sd17408, 32'sd18432, 32'sd19456, 32'sd20480, 32'sd21504, 32'sd22528, 32'sd23552, 32'sd24576,
    32'sd25600, 32'sd26624, 32'sd27648, 32'sd28672, 32'sd29696, 32'sd30720, 32'sd31744, 32'sd32768
  };

  typedef enum logic [1:0] {
    S_SHIFT = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/fifo.sv
// Show-ahead FIFO: dout presents the head entry whenever !empty, zero otherwise.
// Writes while full and reads while empty are dropped.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_mc.sv
// Multi-channel decimating FIR. All lanes share one delay-line shifter and a
// single multiplier that walks channel-major, tap-minor once per output vector.
module fir_decim_mc
  import fir_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int TAPS       = 32,
  parameter int DECIMATION = 8,
  parameter int DATA_SIZE  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS*DATA_SIZE-1:0] x_in_din,
  input  logic                          x_in_wr_en,
  output logic                          x_in_full,
  output logic [CHANNELS*DATA_SIZE-1:0] y_out_dout,
  input  logic                          y_out_rd_en,
  output logic                          y_out_empty,
  input  logic                          coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic [DATA_SIZE-1:0]          coef_din
);

  localparam int LANE_W = CHANNELS * DATA_SIZE;
  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW     = $clog2(TAPS);
  localparam int DW     = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

  state_t state, next_state;

  logic [LANE_W-1:0] x_dout, y_din;
  logic              x_empty, x_rd_en, y_full, y_wr_en;

  logic [CHANNELS-1:0][DATA_SIZE-1:0]            x_vec;
  logic [CHANNELS-1:0][TAPS-1:0][DATA_SIZE-1:0]  dly;
  logic [CHANNELS-1:0][DATA_SIZE-1:0]            acc;
  logic [TAPS-1:0][DATA_SIZE-1:0]                coef;

  logic [DW-1:0] dec_cnt;
  logic [TW-1:0] tap_idx;
  logic [CW-1:0] ch_idx;
  logic          mac_last, dec_last;

  logic signed [DATA_SIZE-1:0]   mac_coef, mac_samp, mac_term;
  logic signed [2*DATA_SIZE-1:0] mac_prod;

  fifo #(.WIDTH(LANE_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (x_in_wr_en),
    .din   (x_in_din),
    .full  (x_in_full),
    .rd_en (x_rd_en),
    .dout  (x_dout),
    .empty (x_empty)
  );

  fifo #(.WIDTH(LANE_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (y_wr_en),
    .din   (y_din),
    .full  (y_full),
    .rd_en (y_out_rd_en),
    .dout  (y_out_dout),
    .empty (y_out_empty)
  );

  assign x_vec    = x_dout;
  assign y_din    = acc;
  assign mac_last = (ch_idx == CW'(CHANNELS-1)) && (tap_idx == TW'(TAPS-1));
  assign dec_last = (dec_cnt == DW'(DECIMATION-1));

  // One shared multiplier; full-width product, floor-scaled, then wrapped to lane width.
  assign mac_coef = coef[tap_idx];
  assign mac_samp = dly[ch_idx][tap_idx];
  assign mac_prod = (2*DATA_SIZE)'(mac_coef) * (2*DATA_SIZE)'(mac_samp);
  assign mac_term = DATA_SIZE'(mac_prod >>> FRAC_BITS);

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_SHIFT;
    else       state <= next_state;
  end

  // Next-state and FIFO strobes; input is only popped while shifting.
  always_comb begin
    next_state = state;
    x_rd_en    = 1'b0;
    y_wr_en    = 1'b0;
    unique case (state)
      S_SHIFT: if (!x_empty) begin
        x_rd_en = 1'b1;
        if (dec_last) next_state = S_MAC;
      end
      S_MAC:   if (mac_last) next_state = S_WRITE;
      S_WRITE: if (!y_full) begin
        y_wr_en    = 1'b1;
        next_state = S_SHIFT;
      end
      default: next_state = S_SHIFT;
    endcase
  end

  // Coefficient RAM: reloads the default table on reset, writable in any state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= DATA_SIZE'(DEFAULT_COEF[i % COEF_TABLE_LEN]);
    end else if (coef_wr_en) begin
      coef[coef_addr] <= coef_din;
    end
  end

  // Delay lines, decimation count, MAC indices and lane accumulators.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dly     <= '0;
      acc     <= '0;
      dec_cnt <= '0;
      tap_idx <= '0;
      ch_idx  <= '0;
    end else begin
      if (x_rd_en) begin
        for (int k = 0; k < CHANNELS; k++) begin
          for (int i = TAPS-1; i > 0; i--) dly[k][i] <= dly[k][i-1];
          dly[k][0] <= x_vec[k];
        end
        if (dec_last) begin
          dec_cnt <= '0;
          acc     <= '0;
        end else begin
          dec_cnt <= dec_cnt + DW'(1);
        end
      end
      if (state == S_MAC) begin
        acc[ch_idx] <= acc[ch_idx] + mac_term;
        if (tap_idx == TW'(TAPS-1)) begin
          tap_idx <= '0;
          ch_idx  <= mac_last ? '0 : ch_idx + CW'(1);
        end else begin
          tap_idx <= tap_idx + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_mc.sv
// Directed bench for fir_decim_mc with CHANNELS=2, TAPS=4, DECIMATION=2.
module tb_fir_decim_mc;

  localparam int CH = 2, T = 4, D = 2, DS = 32, FD = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [CH*DS-1:0] x_in_din = '0;
  logic           x_in_wr_en = 1'b0;
  logic           x_in_full;
  logic [CH*DS-1:0] y_out_dout;
  logic           y_out_rd_en = 1'b0;
  logic           y_out_empty;
  logic           coef_wr_en = 1'b0;
  logic [1:0]     coef_addr = '0;
  logic [DS-1:0]  coef_din = '0;

  fir_decim_mc #(.CHANNELS(CH), .TAPS(T), .DECIMATION(D), .DATA_SIZE(DS), .FIFO_DEPTH(FD)) dut (
    .clock       (clock),
    .reset       (reset),
    .x_in_din    (x_in_din),
    .x_in_wr_en  (x_in_wr_en),
    .x_in_full   (x_in_full),
    .y_out_dout  (y_out_dout),
    .y_out_rd_en (y_out_rd_en),
    .y_out_empty (y_out_empty),
    .coef_wr_en  (coef_wr_en),
    .coef_addr   (coef_addr),
    .coef_din    (coef_din)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int hist0[$];
  int hist1[$];
  int cm[4];
  logic seen_full;

  typedef struct {
    int a0, b0, a1, b1;
    int e0, e1;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference FIR: sum over taps of floor(coef*x / 2^10), wrapped to 32 bits.
  function automatic logic [31:0] ref_lane(input int ch, input int n);
    logic [31:0] a = '0;
    for (int i = 0; i < 4; i++) begin
      int idx = n - 1 - i;
      int x = 0;
      longint p;
      if (idx >= 0) x = (ch == 0) ? hist0[idx] : hist1[idx];
      p = longint'(cm[i]) * longint'(x);
      p = p >>> 10;
      a = a + 32'(p);
    end
    return a;
  endfunction

  task automatic model_reset();
    hist0.delete();
    hist1.delete();
    for (int i = 0; i < 4; i++) cm[i] = (i + 1) * 1024;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_coef(input int addr, input int val);
    coef_wr_en = 1'b1;
    coef_addr  = 2'(addr);
    coef_din   = 32'(val);
    @(negedge clock);
    coef_wr_en = 1'b0;
    cm[addr]   = val;
  endtask

  task automatic push(input int a, input int b);
    x_in_din   = {32'(b), 32'(a)};
    x_in_wr_en = 1'b1;
    @(negedge clock);
    x_in_wr_en = 1'b0;
    hist0.push_back(a);
    hist1.push_back(b);
  endtask

  task automatic push_wait(input string nm, input int a, input int b);
    int w = 0;
    while (x_in_full && w < 2000) begin
      seen_full = 1'b1;
      @(negedge clock);
      w++;
    end
    if (x_in_full) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_push_timeout: x_in_full stuck at 1", nm);
    end
    push(a, b);
  endtask

  task automatic wait_out(input string nm, output int lat);
    lat = 0;
    while (y_out_empty && lat < 500) begin
      @(negedge clock);
      lat++;
    end
    if (y_out_empty) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: y_out_empty stayed 1", nm);
    end
  endtask

  task automatic pop_check(input string nm, input logic [31:0] e0, input logic [31:0] e1);
    int lat;
    wait_out(nm, lat);
    check(nm, y_out_dout, {e1, e0});
    y_out_rd_en = 1'b1;
    @(negedge clock);
    y_out_rd_en = 1'b0;
  endtask

  task automatic pop_model(input string nm, input int npops);
    pop_check(nm, ref_lane(0, npops), ref_lane(1, npops));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    model_reset();
    // Coefs are (i+1)*1024, so each output is x[n] + 2x[n-1] + 3x[n-2] + 4x[n-3].
    tbl[0] = '{a0: 1024, b0: -1024, a1: 0,  b1: 0,   e0: 2048, e1: -2048};
    tbl[1] = '{a0: 0,    b0: 0,     a1: 0,  b1: 0,   e0: 4096, e1: -4096};
    tbl[2] = '{a0: 0,    b0: 0,     a1: 0,  b1: 0,   e0: 0,    e1: 0};
    tbl[3] = '{a0: 5,    b0: -2,    a1: 7,  b1: 3,   e0: 17,   e1: -1};
    tbl[4] = '{a0: -3,   b0: 11,    a1: 100, b1: -50, e0: 135, e1: -27};

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_x_in_full", 64'(x_in_full), 64'd0);
    check("rst_y_out_empty", 64'(y_out_empty), 64'd1);
    check("rst_y_out_dout", y_out_dout, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Read while empty is ignored
    y_out_rd_en = 1'b1;
    @(negedge clock);
    y_out_rd_en = 1'b0;
    check("rd_empty_flag", 64'(y_out_empty), 64'd1);
    check("rd_empty_dout", y_out_dout, 64'd0);

    // Impulse and general patterns from the table
    for (int i = 0; i < 5; i++) begin
      push(tbl[i].a0, tbl[i].b0);
      push(tbl[i].a1, tbl[i].b1);
      if (i == 0) begin
        wait_out("latency", lat);
        check("latency", 64'(lat), 64'(CH * T + 2));
      end
      pop_check($sformatf("tbl%0d", i), 32'(tbl[i].e0), 32'(tbl[i].e1));
    end
    check("tbl_drained", 64'(y_out_empty), 64'd1);

    // Coefficient update ahead of the impulse
    do_reset();
    set_coef(1, 0);
    push(1024, -1024); push(0, 0);
    pop_check("coef_upd0", 32'd0, 32'd0);
    push(0, 0); push(0, 0);
    pop_check("coef_upd1", 32'd4096, -32'sd4096);

    // Reset three cycles into S_MAC: partial result dropped, coefs reloaded
    push(1024, -1024); push(0, 0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    check("midmac_empty", 64'(y_out_empty), 64'd1);
    check("midmac_dout", y_out_dout, 64'd0);
    check("midmac_full", 64'(x_in_full), 64'd0);
    repeat (30) @(negedge clock);
    check("midmac_no_out", 64'(y_out_empty), 64'd1);
    push(1024, -1024); push(0, 0);
    pop_check("post_rst0", 32'd2048, -32'sd2048);
    push(0, 0); push(0, 0);
    pop_check("post_rst1", 32'd4096, -32'sd4096);
    push(0, 0); push(0, 0);
    pop_check("post_rst2", 32'd0, 32'd0);

    // Floor scaling: 512*3/1024 = 1.5 -> 1, 512*-3/1024 = -1.5 -> -2
    do_reset();
    set_coef(0, 512); set_coef(1, 0); set_coef(2, 0); set_coef(3, 0);
    push(3, -3); push(3, -3);
    pop_check("floor", 32'd1, -32'sd2);

    // Wrap: 0x7FFFFFFF per tap -> 0xFFFFFFFE then 0xFFFFFFFC; 0x80000001 -> 2 then 4
    do_reset();
    for (int i = 0; i < 4; i++) set_coef(i, 1024);
    push(32'h7FFF_FFFF, 32'h8000_0001); push(32'h7FFF_FFFF, 32'h8000_0001);
    pop_model("wrap0", 2);
    push(32'h7FFF_FFFF, 32'h8000_0001); push(32'h7FFF_FFFF, 32'h8000_0001);
    pop_model("wrap1", 4);

    // Back-pressure: 40 inputs with no reads, then drain 20 outputs in order
    do_reset();
    seen_full = 1'b0;
    for (int n = 1; n <= 40; n++) push_wait("bp", n, -2 * n);
    check("bp_seen_full", 64'(seen_full), 64'd1);
    repeat (200) @(negedge clock);
    check("bp_out_ready", 64'(y_out_empty), 64'd0);
    for (int m = 1; m <= 20; m++) pop_model($sformatf("bp%0d", m), 2 * m);
    check("bp_drained", 64'(y_out_empty), 64'd1);

    // Write while full is dropped; stream of 50 accepted inputs unchanged
    do_reset();
    for (int n = 1; n <= 50; n++) push_wait("ovf", 100 + n, 3 * n);
    repeat (50) @(negedge clock);
    check("ovf_full", 64'(x_in_full), 64'd1);
    x_in_din   = {32'h5555_5555, 32'hDEAD_BEEF};
    x_in_wr_en = 1'b1;
    @(negedge clock);
    x_in_wr_en = 1'b0;
    check("ovf_still_full", 64'(x_in_full), 64'd1);
    for (int m = 1; m <= 25; m++) pop_model($sformatf("ovf%0d", m), 2 * m);
    repeat (40) @(negedge clock);
    check("ovf_drained", 64'(y_out_empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
